sub_seq_16b: RTL
================

SUB_SEQ_16B -- requirements
Module: sub_seq_16b

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4, minimum 4.
REQ-002 Parameter NIB, default WIDTH/4, number of nibble steps; derived, never overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  minuend.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 bin  input  1  borrow-in, subtracted at nibble 0.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-013 bout  output  1  final borrow-out (1 when a < b + bin, unsigned).
REQ-014 zero  output  1  diff == 0.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 The block SHALL compute diff serially, one 4-bit nibble per cycle, through one shared sub_4b instance.
REQ-017 The sub_4b contract: out = x - y - Cin mod 16; Cout = 1 on borrow.
REQ-018 FSM states IDLE, RUN, DONE.
- IDLE -> RUN on in_valid && in_ready.
- RUN -> DONE after step NIB-1.
- DONE -> IDLE on out_ready.
REQ-019 in_ready SHALL be 1 only in IDLE; in_valid in RUN/DONE is ignored; operands are not latched then.
REQ-020 On acceptance, a, b and bin SHALL be captured into internal registers; later input changes have no effect.
REQ-021 Step counter: 0..NIB-1.
- Step k feeds nibble k of a and b to sub_4b.
- Cin is bin for k=0, else the borrow registered from step k-1.
- out is written into diff nibble k.
REQ-022 Latency: out_valid rises exactly NIB+1 cycles after the acceptance edge (4 RUN cycles at default WIDTH).
REQ-023 In DONE, out_valid=1 and diff/bout/zero SHALL hold stable until the handshake edge where out_ready=1.
REQ-024 There is no bypass: the cycle after DONE -> IDLE, in_ready=1 and out_valid=0. A new request is accepted no earlier than that cycle.
REQ-025 out_ready in IDLE/RUN SHALL have no effect.
REQ-026 diff/bout/zero SHALL retain the last result after leaving DONE until the next acceptance clears them.
REQ-027 zero SHALL be valid whenever out_valid=1.

Reset
REQ-028 While rst_n=0:
- state = IDLE, step counter = 0, internal borrow = 0.
- diff = 0, bout = 0, zero = 0, out_valid = 0, busy = 0.
- in_ready SHALL be 0 during reset and 1 from the first clock edge after release.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL abort the operation immediately, asynchronously. No partial result is ever presented.

Structure
REQ-030 The state encoding (IDLE/RUN/DONE) and the nibble width constant 4 SHALL live in shared package sub_pkg.
REQ-031 The block SHALL instantiate exactly one sub_4b (ports x, y, out, Cin, Cout); no other arithmetic on the datapath.
REQ-032 The step counter width SHALL be clog2(NIB), minimum 1.

Verification
REQ-033 a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, zero=0; out_valid 5 cycles after acceptance.
REQ-034 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; borrow ripples through all 4 steps.
REQ-035 a=0x8000, b=0x7FFF, bin=1 -> diff=0x0000, bout=0, zero=1.
REQ-036 Back-pressure with a=0x00FF, b=0x000F, out_ready=0 for 6 cycles after out_valid:
- diff stays 0x00F0 and in_ready stays 0.
- in_valid pulses with other operands during that time are ignored.
REQ-037 rst_n pulsed low during RUN step 2 -> outputs zero immediately. Next request a=5, b=3 -> diff=0x0002, no contamination from the aborted operation.
REQ-038 Back-to-back: out_ready held 1 and in_valid held 1 -> acceptances exactly NIB+3 cycles apart; each result matches a reference model.

Source files
------------

// File: rtl/sub_pkg.sv
//------------------------------------------------------------------------------
// Module   : sub_pkg
// Brief    : Shared FSM encoding, nibble width and sizing helper for sub_seq_16b
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sub_pkg;

    localparam int c_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int step_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_4b.sv
//------------------------------------------------------------------------------
// Module   : sub_4b
// Brief    : 4-bit subtractor with borrow in/out: out = x - y - Cin mod 16
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sub_4b
    import sub_pkg::*;
(
    input  logic [c_NIBBLE_W-1:0] x,
    input  logic [c_NIBBLE_W-1:0] y,
    input  logic                  Cin,
    output logic [c_NIBBLE_W-1:0] out,
    output logic                  Cout
);

    // The extra top bit goes negative exactly when a borrow is needed.
    logic [c_NIBBLE_W:0] w_res;

    assign w_res = {1'b0, x} - {1'b0, y} - {{c_NIBBLE_W{1'b0}}, Cin};
    assign out   = w_res[c_NIBBLE_W-1:0];
    assign Cout  = w_res[c_NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/sub_seq_16b.sv
//------------------------------------------------------------------------------
// Module   : sub_seq_16b
// Brief    : Nibble-serial subtractor (a - b - bin) with valid/ready handshakes
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sub_seq_16b
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / c_NIBBLE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             busy
);

    localparam int c_STEP_W = step_w(NIB);

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_accept;
    logic                    r_live;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_b;
    logic [WIDTH-1:0]        r_work;
    logic [WIDTH-1:0]        w_work_next;
    logic [WIDTH-1:0]        r_diff;
    logic                    r_borrow;
    logic                    r_fin;
    logic                    r_bout;
    logic                    r_zero;
    logic [c_STEP_W-1:0]     r_step;
    logic [c_NIBBLE_W-1:0]   w_x;
    logic [c_NIBBLE_W-1:0]   w_y;
    logic [c_NIBBLE_W-1:0]   w_out;
    logic                    w_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_live) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_fin) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Select the current nibble and splice the sub_4b result back in place.
    always_comb begin
        w_x         = '0;
        w_y         = '0;
        w_work_next = r_work;
        for (int k = 0; k < NIB; k++) begin
            if (r_step == c_STEP_W'(k)) begin
                w_x = r_a[k*c_NIBBLE_W +: c_NIBBLE_W];
                w_y = r_b[k*c_NIBBLE_W +: c_NIBBLE_W];
                w_work_next[k*c_NIBBLE_W +: c_NIBBLE_W] = w_out;
            end
        end
    end

    sub_4b u_sub_4b (
        .x    (w_x),
        .y    (w_y),
        .Cin  (r_borrow),
        .out  (w_out),
        .Cout (w_cout)
    );

    // After the last nibble, one publish cycle moves diff/bout/zero out
    // together, so the visible outputs never show a half-built result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_fin    <= 1'b0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_step   <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_borrow <= bin;
                r_work   <= '0;
                r_diff   <= '0;
                r_bout   <= 1'b0;
                r_zero   <= 1'b0;
                r_fin    <= 1'b0;
                r_step   <= '0;
            end else if (r_state == ST_RUN) begin
                if (!r_fin) begin
                    r_work   <= w_work_next;
                    r_borrow <= w_cout;
                    if (r_step == c_STEP_W'(NIB - 1)) begin
                        r_fin <= 1'b1;
                    end else begin
                        r_step <= r_step + c_STEP_W'(1);
                    end
                end else begin
                    r_diff <= r_work;
                    r_bout <= r_borrow;
                    r_zero <= (r_work == '0);
                end
            end
        end
    end

    assign in_ready  = r_live && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign zero      = r_zero;

endmodule

`default_nettype wire
